// File: rtl/async_strobe_capture.sv
// Captures a word from an async source over a 4-phase strobe/ack handshake
// and presents it on a valid/ready stream; ack is withheld while the sink is full.
//
// Ports:
//   clk, reset            - clock, async active-high reset
//   strobe_in, data_in    - async request and quasi-static data
//   ack_out               - registered handshake back to the source
//   out_valid, out_ready  - stream handshake
//   out_data              - captured word
//   abort_pulse           - one-cycle pulse when strobe drops before capture
module async_strobe_capture #(
  parameter int WIDTH       = 8,
  parameter int EXTRA_DEPTH = 0,
  parameter int SETTLE      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             abort_pulse
);

  localparam int DEPTH = 2 + EXTRA_DEPTH;
  localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOW,
    S_IDLE,
    S_SETTLE
  } state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] sync_q, sync_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             abort_q, abort_d;
  logic             strobe_s;

  assign strobe_s    = sync_q[DEPTH-1];
  assign ack_out     = ack_q;
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign abort_pulse = abort_q;

  always_comb begin
    sync_d  = {sync_q[DEPTH-2:0], strobe_in};
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    abort_d = 1'b0;

    // A beat leaving the stream; a capture below may refill it on the same edge.
    if (valid_q && out_ready) valid_d = 1'b0;

    unique case (state_q)
      S_WAIT_LOW: begin
        if (!strobe_s) begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
        end
      end
      S_IDLE: begin
        if (strobe_s) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (!strobe_s) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!valid_q || out_ready) begin
          data_d  = data_in;
          valid_d = 1'b1;
          ack_d   = 1'b1;
          state_d = S_WAIT_LOW;
        end
        // otherwise stall here: sink full, ack stays low
      end
      default: state_d = S_WAIT_LOW;
    endcase
  end

  // Chain resets to ones so a strobe held through reset is not a new request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '1;
      state_q <= S_WAIT_LOW;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_async_strobe_capture.sv
// Self-checking bench for async_strobe_capture: three instances
// (default, long settle, deep sync) driven from one clock.
module tb_async_strobe_capture;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: DEPTH=2, SETTLE=2
  logic       a_stb, a_ack, a_vld, a_rdy, a_abt;
  logic [7:0] a_din, a_dout;
  // Instance B: DEPTH=2, SETTLE=4
  logic       b_stb, b_ack, b_vld, b_abt;
  logic [7:0] b_din, b_dout;
  // Instance C: DEPTH=3, SETTLE=1
  logic       c_stb, c_ack, c_vld, c_abt;
  logic [7:0] c_din, c_dout;

  async_strobe_capture #(.WIDTH(8), .EXTRA_DEPTH(0), .SETTLE(2)) u_a (
    .clk(clk), .reset(reset), .strobe_in(a_stb), .data_in(a_din),
    .ack_out(a_ack), .out_valid(a_vld), .out_ready(a_rdy),
    .out_data(a_dout), .abort_pulse(a_abt));

  async_strobe_capture #(.WIDTH(8), .EXTRA_DEPTH(0), .SETTLE(4)) u_b (
    .clk(clk), .reset(reset), .strobe_in(b_stb), .data_in(b_din),
    .ack_out(b_ack), .out_valid(b_vld), .out_ready(1'b1),
    .out_data(b_dout), .abort_pulse(b_abt));

  async_strobe_capture #(.WIDTH(8), .EXTRA_DEPTH(1), .SETTLE(1)) u_c (
    .clk(clk), .reset(reset), .strobe_in(c_stb), .data_in(c_din),
    .ack_out(c_ack), .out_valid(c_vld), .out_ready(1'b1),
    .out_data(c_dout), .abort_pulse(c_abt));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_ack(input logic lvl, input string tag);
    int n = 0;
    while (a_ack !== lvl && n < 60) begin
      tick();
      n++;
    end
    chk(tag, a_ack, lvl);
  endtask

  // Scoreboard for instance A: words pushed when strobed, popped on handshake.
  logic [7:0] sb_q[$];
  int a_beats = 0;
  int a_aborts = 0;
  int b_aborts = 0;
  int b_vld_seen = 0;
  int b_ack_seen = 0;

  always @(negedge clk) begin
    if (!reset && a_vld && a_rdy) begin
      a_beats++;
      if (sb_q.size() == 0) begin
        chk("a_extra_beat", 32'(a_dout), 32'hFFFF_FFFF);
      end else begin
        chk("a_beat_data", 32'(a_dout), 32'(sb_q.pop_front()));
      end
    end
    if (a_abt) a_aborts++;
    if (b_abt) b_aborts++;
    if (b_vld) b_vld_seen++;
    if (b_ack) b_ack_seen++;
  end

  initial begin
    reset = 1'b1;
    a_stb = 0; a_din = 0; a_rdy = 1;
    b_stb = 0; b_din = 0;
    c_stb = 0; c_din = 0;
    #2;
    chk("rst_ack", a_ack, 0);
    chk("rst_vld", a_vld, 0);
    chk("rst_data", 32'(a_dout), 0);
    chk("rst_abort", a_abt, 0);
    tick(); tick();
    reset = 1'b0;
    repeat (6) tick();

    // 1. Basic latency and ack release
    a_din = 8'hA5; a_stb = 1; sb_q.push_back(8'hA5);
    repeat (4) tick();
    chk("t1_vld_e4", a_vld, 0);
    chk("t1_ack_e4", a_ack, 0);
    tick();
    chk("t1_vld_e5", a_vld, 1);
    chk("t1_ack_e5", a_ack, 1);
    chk("t1_data_e5", 32'(a_dout), 32'hA5);
    tick();
    chk("t1_vld_e6", a_vld, 0);
    a_stb = 0;
    tick(); tick();
    chk("t1_ack_hold", a_ack, 1);
    tick();
    chk("t1_ack_rel", a_ack, 0);
    repeat (3) tick();

    // 2. Backpressure
    a_rdy = 0;
    a_din = 8'h11; a_stb = 1; sb_q.push_back(8'h11);
    wait_a_ack(1, "t2_ack1");
    a_stb = 0;
    wait_a_ack(0, "t2_ack1_rel");
    a_din = 8'h22; a_stb = 1; sb_q.push_back(8'h22);
    repeat (10) tick();
    chk("t2_stall_ack", a_ack, 0);
    chk("t2_stall_vld", a_vld, 1);
    chk("t2_stall_data", 32'(a_dout), 32'h11);
    a_rdy = 1;
    tick();
    chk("t2_swap_ack", a_ack, 1);
    chk("t2_swap_vld", a_vld, 1);
    chk("t2_swap_data", 32'(a_dout), 32'h22);
    tick();
    chk("t2_drain_vld", a_vld, 0);
    a_stb = 0;
    wait_a_ack(0, "t2_ack2_rel");
    tick();

    // 4. Back-to-back full 4-phase cycles
    begin
      int beats0;
      int ab0;
      beats0 = a_beats;
      ab0 = a_aborts;
      for (int i = 1; i <= 8; i++) begin
        a_din = 8'(i); a_stb = 1; sb_q.push_back(8'(i));
        wait_a_ack(1, "t4_ack");
        a_stb = 0;
        wait_a_ack(0, "t4_rel");
      end
      repeat (3) tick();
      chk("t4_beats", 32'(a_beats - beats0), 8);
      chk("t4_aborts", 32'(a_aborts - ab0), 0);
      chk("t4_sb_empty", 32'(sb_q.size()), 0);
    end

    // 3. Abort on SETTLE=4 instance
    b_aborts = 0; b_vld_seen = 0; b_ack_seen = 0;
    b_din = 8'h99; b_stb = 1;
    repeat (3) tick();
    b_stb = 0;
    repeat (12) tick();
    chk("t3_aborts", 32'(b_aborts), 1);
    chk("t3_vld_seen", 32'(b_vld_seen), 0);
    chk("t3_ack_seen", 32'(b_ack_seen), 0);

    // 6. Deep sync, SETTLE=1
    c_din = 8'h3C; c_stb = 1;
    repeat (4) tick();
    chk("t6_vld_e4", c_vld, 0);
    tick();
    chk("t6_vld_e5", c_vld, 1);
    chk("t6_data_e5", 32'(c_dout), 32'h3C);
    c_stb = 0;
    repeat (6) tick();

    // 5. Reset while in WAIT_LOW with strobe high
    a_rdy = 0;
    a_din = 8'h5A; a_stb = 1;
    wait_a_ack(1, "t5_ack");
    chk("t5_vld_pre", a_vld, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_ack", a_ack, 0);
    chk("t5_async_vld", a_vld, 0);
    tick();
    reset = 1'b0;
    a_rdy = 1;
    repeat (15) tick();
    chk("t5_no_cap_vld", a_vld, 0);
    chk("t5_no_cap_ack", a_ack, 0);
    a_stb = 0;
    repeat (5) tick();
    a_din = 8'h77; a_stb = 1; sb_q.push_back(8'h77);
    wait_a_ack(1, "t5_ack2");
    chk("t5_data2", 32'(a_dout), 32'h77);
    a_stb = 0;
    wait_a_ack(0, "t5_rel2");
    repeat (3) tick();
    chk("t5_sb_empty", 32'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
